multiword_add_sequencer: RTL
============================

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: chunk width in bits fed to the per-cycle adder; legal values are 1 or more.
REQ-002 The block SHALL have parameter WORDS, default 4: number of chunks per operand; legal values are 2 or more.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk SHALL be an input, 1 bit: the clock, rising-edge active.
REQ-005 Port rst_n SHALL be an input, 1 bit: the asynchronous active-low reset.
REQ-006 Port in_valid SHALL be an input, 1 bit: the operand pair and ci are valid.
REQ-007 Port in_ready SHALL be an output, 1 bit: the block can accept an operand pair.
REQ-008 Ports a and b SHALL be inputs, WIDTH*WORDS bits each: the operands.
REQ-009 Port ci SHALL be an input, 1 bit: the carry into chunk 0.
REQ-010 Port out_valid SHALL be an output, 1 bit: sum and co are valid.
REQ-011 Port out_ready SHALL be an input, 1 bit: the consumer accepts the result.
REQ-012 Port sum SHALL be an output, WIDTH*WORDS bits: the registered result.
REQ-013 Port co SHALL be an output, 1 bit: the carry out of the top chunk.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 An operand pair SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_ready SHALL equal 1 only in IDLE.
REQ-016 On accept, the block SHALL latch a, b and ci into internal registers, clear chunk index idx to 0 and go to RUN; later changes on a, b and ci SHALL have no effect until the next accept.
REQ-017 Each RUN edge SHALL compute {c, s} = a_chunk[idx] + b_chunk[idx] + carry_reg, write s to sum[idx*WIDTH +: WIDTH], load c into carry_reg and increment idx.
REQ-018 On the RUN edge with idx = WORDS-1, the block SHALL load co from c, go to DONE and set out_valid to 1; idx SHALL NOT wrap into a further RUN cycle.
REQ-019 Latency SHALL be exactly WORDS rising edges from the accept edge to the edge that asserts out_valid.
REQ-020 In DONE, sum, co and out_valid SHALL hold stable until an edge where out_ready is 1; on that edge the block SHALL go to IDLE and clear out_valid.
REQ-021 out_ready in any state other than DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored with no latching.
REQ-022 sum chunks not yet written in the current operation SHALL keep their previous values; sum SHALL be fully valid only while out_valid is 1.
REQ-023 Throughput SHALL be one result per WORDS+2 cycles at most; back-to-back overlap is not required.

Reset
REQ-024 While rst_n is 0, the block SHALL immediately set the state to IDLE and idx, carry_reg, sum, co and out_valid to 0; in_ready SHALL be 1.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation with no partial result presented.
REQ-026 Release of rst_n SHALL take effect at the first rising edge after deassertion; no accept SHALL occur before that edge.

Structure
REQ-027 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared include file, msa_defs.vh, reused by the bench.
REQ-028 The per-cycle arithmetic SHALL be one combinational sub-module, chunk_adder(co, sum, a, b, ci), parameterised by WIDTH.
REQ-029 chunk_adder SHALL use a generate case on WIDTH: a 1-bit full adder for WIDTH 1, and a behavioural WIDTH-bit add otherwise; its generate block SHALL be named adder.
REQ-030 The sequencer SHALL contain only the FSM, idx counter, operand registers, carry_reg and result registers.

Verification
REQ-031 With WIDTH=4, WORDS=4: a=16'h00FF, b=16'h0001, ci=0 -> sum=16'h0100, co=0, out_valid rises exactly 4 edges after accept.
REQ-032 With WIDTH=4, WORDS=4: a=16'hFFFF, b=16'h0001, ci=0 -> sum=16'h0000, co=1, with the carry propagated through all 4 chunks.
REQ-033 With WIDTH=4, WORDS=4: a=0, b=0, ci=1 -> sum=16'h0001, co=0; a and b changed after accept -> result unchanged.
REQ-034 Hold out_ready=0 for 3 cycles in DONE -> sum, co and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-035 Assert rst_n=0 at idx=2 of RUN -> asynchronously state=IDLE, sum=0, co=0, out_valid=0, in_ready=1.
REQ-036 With WIDTH=1, WORDS=8: a=8'hAA, b=8'h55, ci=1 -> sum=8'h00, co=1, latency 8 edges.

Source files
------------

// File: rtl/multiword_add_sequencer_pkg.sv
// Types and helpers shared by the multiword add sequencer and its chunk adder.
package multiword_add_sequencer_pkg;
`include "msa_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE = `MSA_ST_IDLE,
        ST_RUN  = `MSA_ST_RUN,
        ST_DONE = `MSA_ST_DONE
    } msa_state_e;

    // Width of a counter able to index WORDS chunks.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/msa_defs.vh
// Shared state encodings for the multiword add sequencer.
// The RTL package and the bench both include this file.
`ifndef MSA_DEFS_VH
`define MSA_DEFS_VH
`define MSA_ST_IDLE 2'd0
`define MSA_ST_RUN  2'd1
`define MSA_ST_DONE 2'd2
`endif

// File: rtl/multiword_add_sequencer_chunk_adder.sv
// Combinational WIDTH-bit adder with carry in/out, used once per sequencer cycle.
module chunk_adder #(
    parameter int WIDTH = 4
) (
    output logic             co,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci
);

    generate
        case (WIDTH)
            1: begin : adder
                assign sum = a ^ b ^ ci;
                assign co  = (a[0] & b[0]) | (a[0] & ci) | (b[0] & ci);
            end
            default: begin : adder
                assign {co, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
            end
        endcase
    endgenerate

endmodule

// File: rtl/multiword_add_sequencer.sv
// Sequential multiword adder: adds one WIDTH-bit chunk per cycle, LSB chunk first,
// with a valid/ready handshake on both the operand and the result side.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   ci,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   co
);

    localparam int TOTAL_W = WIDTH * WORDS;
    localparam int IDX_W   = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    msa_state_e         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [TOTAL_W-1:0] r_a;
    logic [TOTAL_W-1:0] r_b;
    logic               r_carry;
    logic [TOTAL_W-1:0] r_sum;
    logic               r_co;
    logic               r_out_valid;
    logic               r_in_ready;

    logic [WIDTH-1:0]   w_a_chunk;
    logic [WIDTH-1:0]   w_b_chunk;
    logic [WIDTH-1:0]   w_s;
    logic               w_c;

    // r_idx never exceeds WORDS-1, so the shift always selects a real chunk.
    assign w_a_chunk = WIDTH'(r_a >> (int'(r_idx) * WIDTH));
    assign w_b_chunk = WIDTH'(r_b >> (int'(r_idx) * WIDTH));

    chunk_adder #(
        .WIDTH (WIDTH)
    ) u_chunk_adder (
        .co  (w_c),
        .sum (w_s),
        .a   (w_a_chunk),
        .b   (w_b_chunk),
        .ci  (r_carry)
    );

    // Control FSM, operand capture, chunk index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_co        <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= ci;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum[int'(r_idx) * WIDTH +: WIDTH] <= w_s;
                    r_carry <= w_c;
                    // The last chunk finishes the operation instead of wrapping idx.
                    if (r_idx == LAST_IDX) begin
                        r_co        <= w_c;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx       <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign co        = r_co;

endmodule
